shift_counter: RTL

Parametrised shift-register counter. It generalises the fixed one-hot ring counter with the following:
- Run-time selectable ring or Johnson (twisted-ring) mode.
- Shift direction control, clock enable and parallel load.
- Illegal-state self-correction, a legality flag and a wrap pulse.

It is the common sequencer/phase generator for the Shift_Counter family. Downstream blocks use count as one-hot or thermometer phase strobes.

---
 rtl/shift_counter.sv | 75 +++++++
 1 files changed

// File: rtl/shift_counter.sv
// Parametrised ring / Johnson shift counter with direction, enable, parallel load,
// illegal-state self-correction, a combinational legality flag and wrap/err pulses.
module shift_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         legal,
  output logic         wrap,
  output logic         err
);

  logic [N-1:0] seed;
  logic [N-1:0] shifted;
  int unsigned  ones;
  int unsigned  edges;

  // Ring seeds with a single one; Johnson seeds with all zeros.
  assign seed = mode ? '0 : {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < N; i++) begin
      ones = ones + {31'd0, count[i]};
    end
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + {31'd0, count[i] ^ count[i+1]};
    end
    legal = mode ? (edges <= 1) : (ones == 1);
  end

  // Johnson inverts the bit that wraps around; ring carries it straight through.
  always_comb begin
    shifted = count;
    case ({mode, dir})
      2'b00:   shifted = {count[N-2:0], count[N-1]};
      2'b01:   shifted = {count[0], count[N-1:1]};
      2'b10:   shifted = {count[N-2:0], ~count[N-1]};
      default: shifted = {~count[0], count[N-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= seed;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        count <= seed;
        wrap  <= 1'b0;
        err   <= 1'b1;
      end else begin
        count <= shifted;
        wrap  <= (shifted == seed);
        err   <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule
